// File: rtl/tone_decoder.sv
// Tone decoder: measures the half-period of a square-wave tone and maps it back to octave*12+note.
// Optional build macro TONE_DEC_PERIOD_OUT_EN adds the hp_last output (last latched half-period).
module tone_decoder #(
   parameter int CNT_W       = 20,
   parameter int TOL         = 2,
   parameter int STABLE_CNT  = 2,
   parameter int SILENCE_CYC = 200000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tone_in,
   output logic             note_valid,
   output logic [7:0]       fullnote,
   output logic [2:0]       octave,
   output logic [3:0]       note,
   output logic             silence,
   output logic             no_match
`ifdef TONE_DEC_PERIOD_OUT_EN
   ,
   output logic [CNT_W-1:0] hp_last
`endif
);

   localparam int ST_W = $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] Q_LIM   = CNT_W'(512 + TOL);
   localparam logic [CNT_W-1:0] SIL_LIM = CNT_W'(SILENCE_CYC);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_NORM   = 2'd1;
   localparam logic [1:0] S_LOOKUP = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [ST_W-1:0] stable_inc(input logic [ST_W-1:0] v);
      return (v == ST_W'(STABLE_CNT)) ? v : v + 1'b1;
   endfunction

   function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
      return (a >= b) ? a - b : b - a;
   endfunction

   // Normalized half-period of each note in the top (512-count) octave, A..G#.
   function automatic logic [9:0] note_period(input logic [3:0] i);
      case (i)
         4'd0:    return 10'd512;
         4'd1:    return 10'd483;
         4'd2:    return 10'd456;
         4'd3:    return 10'd431;
         4'd4:    return 10'd406;
         4'd5:    return 10'd384;
         4'd6:    return 10'd362;
         4'd7:    return 10'd342;
         4'd8:    return 10'd323;
         4'd9:    return 10'd304;
         4'd10:   return 10'd287;
         default: return 10'd271;
      endcase
   endfunction

   logic             tone_p0, tone_p1, tone_p2;
   logic             edge_p2;
   logic             silence_hit;
   logic [CNT_W-1:0] hp_cnt;
   logic [CNT_W-1:0] h_reg;
   logic             h_pend;
   logic [1:0]       state;
   logic [CNT_W-1:0] q;
   logic [3:0]       s;
   logic [3:0]       idx;
   logic [2:0]       oct_r;
   logic [7:0]       prev_cand;
   logic [ST_W-1:0]  stable;
   logic [7:0]       cand;
   logic [ST_W-1:0]  stable_nxt;

   assign edge_p2     = tone_p1 ^ tone_p2;
   assign silence_hit = !silence && !edge_p2 && (hp_cnt == SIL_LIM);

   always_comb begin
      cand       = {5'd0, oct_r} * 8'd12 + {4'd0, idx};
      stable_nxt = (cand == prev_cand) ? stable_inc(stable) : ST_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tone_p0    <= 1'b0;
         tone_p1    <= 1'b0;
         tone_p2    <= 1'b0;
         hp_cnt     <= '0;
         h_reg      <= '0;
         h_pend     <= 1'b0;
         state      <= S_IDLE;
         q          <= '0;
         s          <= '0;
         idx        <= '0;
         oct_r      <= '0;
         prev_cand  <= '0;
         stable     <= '0;
         note_valid <= 1'b0;
         no_match   <= 1'b0;
         fullnote   <= '0;
         octave     <= '0;
         note       <= '0;
         silence    <= 1'b1;
`ifdef TONE_DEC_PERIOD_OUT_EN
         hp_last    <= '0;
`endif
      end else begin
         note_valid <= 1'b0;
         no_match   <= 1'b0;
         tone_p0    <= tone_in;
         tone_p1    <= tone_p0;
         tone_p2    <= tone_p1;

         case (state)
            S_IDLE: begin
               if (h_pend) begin
                  q      <= h_reg;
                  s      <= '0;
                  h_pend <= 1'b0;
                  state  <= S_NORM;
               end
            end
            S_NORM: begin
               if (q > Q_LIM && s < 4'd8) begin
                  q <= q >> 1;
                  s <= s + 4'd1;
               end else if (s < 4'd3 || q > Q_LIM) begin
                  no_match <= 1'b1;
                  state    <= S_IDLE;
               end else begin
                  oct_r <= 3'(4'd8 - s);
                  idx   <= '0;
                  state <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (abs_diff(q[9:0], note_period(idx)) <= 10'(TOL)) begin
                  state <= S_REPORT;
               end else if (idx == 4'd11) begin
                  no_match <= 1'b1;
                  stable   <= '0;
                  state    <= S_IDLE;
               end else begin
                  idx <= idx + 4'd1;
               end
            end
            default: begin
               stable    <= stable_nxt;
               prev_cand <= cand;
               if (stable_nxt == ST_W'(STABLE_CNT) && cand != fullnote) begin
                  fullnote   <= cand;
                  octave     <= oct_r;
                  note       <= idx;
                  note_valid <= 1'b1;
               end
               state <= S_IDLE;
            end
         endcase

         // An edge after silence only re-arms; a later edge overwrites any H not yet consumed.
         if (edge_p2) begin
            hp_cnt <= '0;
            if (silence) begin
               silence <= 1'b0;
            end else begin
               h_reg  <= sat_inc(hp_cnt);
               h_pend <= 1'b1;
`ifdef TONE_DEC_PERIOD_OUT_EN
               hp_last <= sat_inc(hp_cnt);
`endif
            end
         end else begin
            hp_cnt <= sat_inc(hp_cnt);
         end

         if (silence_hit) begin
            silence  <= 1'b1;
            fullnote <= '0;
            octave   <= '0;
            note     <= '0;
            stable   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: note decodes go through a scoreboard queue, levels are checked inline.
`timescale 1ns/1ps
module tb_tone_decoder;

   localparam int CNT_W = 20;
   localparam int SIL   = 5000;

   typedef struct {
      int fn;
      int oct;
      int nt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             tone_in;
   logic             note_valid;
   logic [7:0]       fullnote;
   logic [2:0]       octave;
   logic [3:0]       note;
   logic             silence;
   logic             no_match;
`ifdef TONE_DEC_PERIOD_OUT_EN
   logic [CNT_W-1:0] hp_last;
`endif

   int   total = 0;
   int   bad = 0;
   int   nv_cnt = 0;
   int   nm_cnt = 0;
   int   cyc = 0;
   int   last = 0;
   int   nv_ref;
   int   nm_ref;
   exp_t sb[$];

   tone_decoder #(.CNT_W(CNT_W), .TOL(2), .STABLE_CNT(2), .SILENCE_CYC(SIL)) dut (
      .clk        (clk),
      .rst        (rst),
      .tone_in    (tone_in),
      .note_valid (note_valid),
      .fullnote   (fullnote),
      .octave     (octave),
      .note       (note),
      .silence    (silence),
      .no_match   (no_match)
`ifdef TONE_DEC_PERIOD_OUT_EN
      ,
      .hp_last    (hp_last)
`endif
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (no_match === 1'b1) nm_cnt++;
         if (note_valid === 1'b1) begin
            nv_cnt++;
            total++;
            assert (sb.size() > 0) else begin
               bad++;
               $error("FAIL sb_unexpected_valid observed fullnote=%0d expected no pulse", fullnote);
            end
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               total += 3;
               assert (fullnote === 8'(e.fn)) else begin
                  bad++;
                  $error("FAIL sb_fullnote observed=%0d expected=%0d", fullnote, e.fn);
               end
               assert (octave === 3'(e.oct)) else begin
                  bad++;
                  $error("FAIL sb_octave observed=%0d expected=%0d", octave, e.oct);
               end
               assert (note === 4'(e.nt)) else begin
                  bad++;
                  $error("FAIL sb_note observed=%0d expected=%0d", note, e.nt);
               end
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wcyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Toggle the tone line n cycles after the previous toggle (immediately if already past).
   task automatic tog(input int n);
      while (cyc - last < n) begin
         @(posedge clk);
         #1;
      end
      tone_in = ~tone_in;
      last = cyc;
   endtask

   task automatic push(input int fn, input int oc, input int nt);
      exp_t e;
      e.fn = fn;
      e.oct = oc;
      e.nt = nt;
      sb.push_back(e);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      tone_in = 1'b0;
      wcyc(4);
      chk("rst_fullnote", fullnote, 0);
      chk("rst_octave", octave, 0);
      chk("rst_note", note, 0);
      chk("rst_silence", silence, 1);
      chk("rst_note_valid", note_valid, 0);
      chk("rst_no_match", no_match, 0);
`ifdef TONE_DEC_PERIOD_OUT_EN
      chk("rst_hp_last", hp_last, 0);
`endif
      rst = 1'b0;
      last = cyc;

      // 483*8: octave 5, note 1 -> 61
      push(61, 5, 1);
      repeat (3) tog(3864);
      wcyc(40);
      chk("t1_sb_empty", sb.size(), 0);
      chk("t1_nv_count", nv_cnt, 1);
      chk("t1_fullnote", fullnote, 61);
      chk("t1_silence", silence, 0);
`ifdef TONE_DEC_PERIOD_OUT_EN
      chk("t1_hp_last", hp_last, 3864);
`endif

      // 362*8 -> 66, above 63 reported as-is; third period must not re-pulse
      push(66, 5, 6);
      repeat (3) tog(2896);
      wcyc(40);
      chk("t2_sb_empty", sb.size(), 0);
      chk("t2_nv_count", nv_cnt, 2);
      chk("t2_fullnote", fullnote, 66);

      // 287*16 -> octave 4 note 10 = 58, then 3884 (q=485, at tolerance) -> 61
      push(58, 4, 10);
      repeat (2) tog(4592);
      wcyc(40);
      chk("t3_sb_empty_a", sb.size(), 0);
      chk("t3_octave", octave, 4);
      chk("t3_note", note, 10);
      push(61, 5, 1);
      repeat (2) tog(3884);
      wcyc(40);
      chk("t3_sb_empty_b", sb.size(), 0);
      chk("t3_fullnote", fullnote, 61);
      chk("t3_nm_none", nm_cnt, 0);

      // q=390, q=486 (beyond tolerance), and a period too short to normalize
      nv_ref = nv_cnt;
      repeat (2) tog(3120);
      wcyc(40);
      chk("t4_nm_390", nm_cnt, 2);
      tog(3888);
      wcyc(40);
      chk("t4_nm_486", nm_cnt, 3);
      tog(2000);
      wcyc(40);
      chk("t4_nm_short", nm_cnt, 4);
      chk("t4_no_valid", nv_cnt, nv_ref);
      chk("t4_fullnote_kept", fullnote, 61);
      chk("t4_silence", silence, 0);

      // silence after SIL edge-free cycles, then restart
      nm_ref = nm_cnt;
      while (cyc - last < SIL + 100) wcyc(1);
      chk("t5_silence", silence, 1);
      chk("t5_fullnote", fullnote, 0);
      chk("t5_octave", octave, 0);
      chk("t5_note", note, 0);
      push(61, 5, 1);
      tog(3864);
      wcyc(6);
      chk("t5_silence_drop", silence, 0);
      repeat (2) tog(3864);
      wcyc(40);
      chk("t5_sb_empty", sb.size(), 0);
      chk("t5_fullnote_back", fullnote, 61);
      chk("t5_nm_none", nm_cnt, nm_ref);

      // reset while the 287 entry is being searched for
      nv_ref = nv_cnt;
      nm_ref = nm_cnt;
      tog(2296);
      wcyc(12);
      rst = 1'b1;
      tone_in = 1'b0;
      wcyc(3);
      chk("t6_rst_fullnote", fullnote, 0);
      chk("t6_rst_silence", silence, 1);
      rst = 1'b0;
      last = cyc;
`ifdef TONE_DEC_PERIOD_OUT_EN
      chk("t6_hp_last_clr", hp_last, 0);
`endif
      wcyc(40);
      chk("t6_no_valid", nv_cnt, nv_ref);
      chk("t6_no_nm", nm_cnt, nm_ref);
      chk("t6_octave", octave, 0);
      push(70, 5, 10);
      repeat (3) tog(2296);
      wcyc(40);
      chk("t6_sb_empty", sb.size(), 0);
      chk("t6_fullnote", fullnote, 70);
      chk("t6_silence", silence, 0);
`ifdef TONE_DEC_PERIOD_OUT_EN
      chk("t6_hp_last", hp_last, 2296);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
